// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_master
// Function : Single-byte I2C master (START, 7-bit address + R/W, one data byte,
//            STOP) with ACK checking. Define I2C_CLK_STRETCH_EN to add scl_i and
//            honour slave clock stretching.
// Revision : 1.0
// ============================================================================
module i2c_byte_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic [7:0]        rdata,
  output logic              scl_o,
  output logic              sda_oe,
`ifdef I2C_CLK_STRETCH_EN
  input  logic              scl_i,
`endif
  input  logic              sda_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_WDATA,
    S_ACK2, S_RDATA, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic             samp_q, samp_d;
  logic             nack_q, nack_d;
  logic [7:0]       rdata_q, rdata_d;

  logic stall, tick, bit_end, sample, scl_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      samp_q  <= 1'b0;
      nack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      samp_q  <= samp_d;
      nack_q  <= nack_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus levels: SCL high in quarters 1 and 2; data/ACK bits change only at q0.
  always_comb begin
    scl_mid = qtr_q[0] ^ qtr_q[1];
    scl_o   = 1'b1;
    sda_oe  = 1'b0;
    case (state_q)
      S_START: begin
        scl_o  = (qtr_q != 2'd3);
        sda_oe = (qtr_q != 2'd0);
      end
      S_ADDR, S_WDATA: begin
        scl_o  = scl_mid;
        sda_oe = ~shift_q[7];
      end
      S_ACK1, S_ACK2, S_RDATA, S_MACK: scl_o = scl_mid;
      S_STOP: begin
        scl_o  = (qtr_q != 2'd0);
        sda_oe = ~qtr_q[1];
      end
      default: ;
    endcase
  end

  always_comb begin
`ifdef I2C_CLK_STRETCH_EN
    stall = scl_o & ~scl_i;
`else
    stall = 1'b0;
`endif
    tick    = (div_q == c_div_last) && !stall;
    bit_end = tick && (qtr_q == 2'd3);
    sample  = tick && (qtr_q == 2'd1);

    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    samp_d  = samp_q;
    nack_d  = nack_q;
    rdata_d = rdata_q;

    // Timing counters only run while a transfer is on the bus.
    if (state_q != S_IDLE && state_q != S_DONE && !stall) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) qtr_d = qtr_q + 2'd1;
    end
    if (sample) samp_d = sda_i;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          shift_d = {addr, rw};
          wdata_d = wdata;
          rw_d    = rw;
          bit_d   = 3'd7;
          nack_d  = 1'b0;
        end
      end
      S_START: if (bit_end) state_d = S_ADDR;
      S_ADDR, S_WDATA: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_ACK1 : S_ACK2;
        end
      end
      S_ACK1: begin
        if (bit_end) begin
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_WDATA;
            shift_d = wdata_q;
          end
        end
      end
      S_ACK2: begin
        if (bit_end) begin
          nack_d  = samp_q;
          state_d = S_STOP;
        end
      end
      S_RDATA: begin
        if (sample) shift_d = {shift_q[6:0], sda_i};
        if (bit_end) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = S_MACK;
        end
      end
      S_MACK: begin
        if (bit_end) begin
          rdata_d = shift_q;
          state_d = S_STOP;
        end
      end
      S_STOP: if (bit_end) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done  = (state_q == S_DONE);
  assign nack  = nack_q;
  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_byte_master
// Function : Bench for i2c_byte_master with a behavioural slave and a bus
//            monitor that decodes SDA at every SCL rise.
// Revision : 1.0
// ============================================================================
module tb_i2c_byte_master;
  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, nack, scl_o, sda_oe, sda_i;
  logic [7:0] rdata;
  logic       slave_low = 1'b0;

  assign sda_i = ~sda_oe & ~slave_low;

`ifdef I2C_CLK_STRETCH_EN
  int   hold_cnt = 0;
  int   stretch_at = 0;
  logic scl_i;
  assign scl_i = scl_o & (hold_cnt == 0);
`endif

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(CLK_DIV), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .nack(nack), .rdata(rdata),
    .scl_o(scl_o), .sda_oe(sda_oe),
`ifdef I2C_CLK_STRETCH_EN
    .scl_i(scl_i),
`endif
    .sda_i(sda_i)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour for the current transfer
  logic       sl_rw = 1'b0, sl_ack_a = 1'b1, sl_ack_d = 1'b1;
  logic [7:0] sl_rd = '0;
  logic [7:0] rdata_m = '0;

  // Monitor state (owned by the monitor process)
  logic        prev_scl = 1'b1, prev_sda = 1'b1, cur_sda;
  int          rise_cnt = 0, n_start = 0, n_stop = 0, done_cnt = 0;
  logic [31:0] rise_bits = '0;

  // k = number of SCL rises seen so far; returns the level the slave pulls for slot k+1
  function automatic logic slave_drive(int k);
    if (k == 8) return sl_ack_a;
    if (!sl_ack_a) return 1'b0;
    if (k >= 9 && k <= 16) return sl_rw ? ~sl_rd[16-k] : 1'b0;
    if (k == 17) return !sl_rw && sl_ack_d;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    cur_sda = sda_i;
`ifdef I2C_CLK_STRETCH_EN
    if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
`endif
    if (rst) begin
      slave_low = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        rise_cnt = 0; rise_bits = '0; n_start = 0; n_stop = 0; done_cnt = 0;
      end
      if (prev_scl && scl_o && (prev_sda != cur_sda)) begin
        if (prev_sda) n_start++;
        else          n_stop++;
      end
      if (!prev_scl && scl_o) begin
        rise_bits = {rise_bits[30:0], cur_sda};
        rise_cnt++;
`ifdef I2C_CLK_STRETCH_EN
        if (stretch_at != 0 && rise_cnt == stretch_at) hold_cnt = 37;
`endif
      end
      if (prev_scl && !scl_o) slave_low = slave_drive(rise_cnt);
      if (done) done_cnt++;
    end
    prev_scl = scl_o;
    prev_sda = cur_sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] w,
                      input logic ack_a, input logic ack_d, input logic [7:0] rd,
                      input bit stretch, input bit disturb);
    int          cycles;
    int          exp_lat;
    int          exp_n;
    logic [31:0] exp_bits;
    logic        exp_nack;
    sl_rw = r; sl_ack_a = ack_a; sl_ack_d = ack_d; sl_rd = rd;
`ifdef I2C_CLK_STRETCH_EN
    stretch_at = stretch ? 5 : 0;
`endif
    @(posedge clk); #1;
    start = 1'b1; addr = a; rw = r; wdata = w;
    @(posedge clk); #1;
    start = 1'b0; addr = 7'($urandom); wdata = 8'($urandom); rw = ~r;
    check("busy_after_start", busy, 1'b1);
    check("nack_cleared_on_start", nack, 1'b0);

    cycles = 0;
    while (done !== 1'b1 && cycles < 4000) begin
      @(posedge clk); #1;
      cycles++;
      if (disturb && cycles == 100) begin
        start = 1'b1; addr = 7'h7F; rw = 1'b1;
      end else if (disturb && cycles == 101) begin
        start = 1'b0;
      end
    end

    // Reference: bus bits at every SCL rise, from the protocol's framing rules
    exp_bits = '0; exp_n = 0;
    for (int i = 6; i >= 0; i--) begin exp_bits = {exp_bits[30:0], a[i]}; exp_n++; end
    exp_bits = {exp_bits[30:0], r};      exp_n++;
    exp_bits = {exp_bits[30:0], ~ack_a}; exp_n++;
    if (ack_a) begin
      for (int i = 7; i >= 0; i--) begin
        exp_bits = {exp_bits[30:0], (r ? rd[i] : w[i])};
        exp_n++;
      end
      exp_bits = {exp_bits[30:0], (r ? 1'b1 : ~ack_d)};
      exp_n++;
    end
    exp_bits = {exp_bits[30:0], 1'b0};   exp_n++;

    exp_lat  = (ack_a ? 20 : 11) * BIT_CLKS + (stretch ? 37 : 0);
    exp_nack = !ack_a || (!r && !ack_d);
    if (r && ack_a) rdata_m = rd;

    check("done_latency", cycles, exp_lat);
    check("busy_low_at_done", busy, 1'b0);
    check("nack", nack, exp_nack);
    check("rdata", rdata, rdata_m);
    check("sda_bits", rise_bits, exp_bits);
    check("scl_rises", rise_cnt, exp_n);
    check("start_cond", n_start, 1);
    check("stop_cond", n_stop, 1);

    if (disturb) begin
      start = 1'b1; addr = 7'h33; rw = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3 * BIT_CLKS) @(posedge clk);
      #1;
      check("ignored_start_busy", busy, 1'b0);
      check("single_done_pulse", done_cnt, 1);
    end else begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
    end
`ifdef I2C_CLK_STRETCH_EN
    stretch_at = 0;
`endif
  endtask

  initial begin
    int cycles;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_nack", nack, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_scl", scl_o, 1'b1);
    check("rst_sda_oe", sda_oe, 1'b0);
    rst = 1'b0;

    xfer(7'h55, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);   // write, ACKed
    xfer(7'h55, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);   // read C3
    xfer(7'h12, 1'b1, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);   // address NACK
    xfer(7'h2A, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);   // data NACK
    repeat (50) @(posedge clk);
    #1;
    check("nack_holds_idle", nack, 1'b1);
    xfer(7'h01, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of address bit 4
    sl_rw = 1'b0; sl_ack_a = 1'b1; sl_ack_d = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; addr = 7'h00; rw = 1'b0; wdata = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (rise_cnt < 4 && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("reach_addr_bit4", rise_cnt, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rdata_m = 8'h00;
    check("midrst_scl", scl_o, 1'b1);
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdata", rdata, rdata_m);
    rst = 1'b0;
    xfer(7'h6C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3E, 1'b0, 1'b0);

    // Start while busy and on the done cycle: both ignored
    xfer(7'h40, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      xfer(7'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 1'b0, 1'b0);
    end

`ifdef I2C_CLK_STRETCH_EN
    xfer(7'h55, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
